// File: rtl/conv_normalize.sv
// conv_normalize: rounds and saturates convolver results into 12-bit pixels.
// Streams the result memory through a 3-stage read/round/clip pipeline.
module conv_normalize #(
  parameter int AddressBitWidth = 17,
  parameter int InBitWidth      = 20,
  parameter int OutBitWidth     = 12,
  parameter int NoOfPixels      = 2500,
  parameter int ShiftBitWidth   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ShiftBitWidth-1:0]          shift,
  input  logic signed [InBitWidth-1:0]      d_in,
  output logic [AddressBitWidth-1:0]        ReadAddress,
  output logic                              ReadEnable,
  output logic [AddressBitWidth-1:0]        WriteAddress,
  output logic [OutBitWidth-1:0]            d_out,
  output logic                              WriteEnable,
  output logic                              ready,
  output logic [AddressBitWidth-1:0]        sat_count
);

  localparam int RW = InBitWidth + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AddressBitWidth-1:0] LAST =
    AddressBitWidth'(NoOfPixels - 1);
  localparam logic signed [RW-1:0] PIX_MAX =
    RW'((1 << OutBitWidth) - 1);

  logic [1:0]                 state;
  logic [ShiftBitWidth-1:0]   shift_q;
  logic                       accept;

  logic                       rd_v;
  logic [AddressBitWidth-1:0] rd_a;
  logic                       rnd_v;
  logic [AddressBitWidth-1:0] rnd_a;
  logic signed [RW-1:0]       rnd_q;

  logic signed [RW-1:0]       ext;
  logic signed [RW-1:0]       bias;
  logic signed [RW-1:0]       rnd_d;
  logic                       clip_lo;
  logic                       clip_hi;
  logic [OutBitWidth-1:0]     sat_d;

  assign accept = start && ((state == IDLE) || (state == DONE));

  // one extra bit of headroom so the rounding bias never overflows
  always_comb begin
    ext  = {d_in[InBitWidth-1], d_in};
    bias = '0;
    if (shift_q != '0) begin
      bias = RW'(1) << (shift_q - 1'b1);
    end
    rnd_d = (ext + bias) >>> shift_q;
  end

  always_comb begin
    clip_lo = rnd_q[RW-1];
    clip_hi = !rnd_q[RW-1] && (rnd_q > PIX_MAX);
    sat_d   = rnd_q[OutBitWidth-1:0];
    if (clip_lo) begin
      sat_d = '0;
    end else if (clip_hi) begin
      sat_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift_q     <= '0;
      ReadAddress <= '0;
      ReadEnable  <= 1'b0;
      ready       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            shift_q     <= shift;
            ready       <= 1'b0;
            ReadAddress <= '0;
            ReadEnable  <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (ReadAddress == LAST) begin
            ReadEnable <= 1'b0;
            state      <= DRAIN;
          end else begin
            ReadAddress <= ReadAddress + 1'b1;
          end
        end
        DRAIN: begin
          // last write is on the bus once both upstream stages are empty
          if (!rd_v && !rnd_v) begin
            ready <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v         <= 1'b0;
      rd_a         <= '0;
      rnd_v        <= 1'b0;
      rnd_a        <= '0;
      rnd_q        <= '0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      d_out        <= '0;
    end else begin
      rd_v        <= ReadEnable;
      rd_a        <= ReadAddress;
      rnd_v       <= rd_v;
      WriteEnable <= rnd_v;
      if (rd_v) begin
        rnd_a <= rd_a;
        rnd_q <= rnd_d;
      end
      if (rnd_v) begin
        WriteAddress <= rnd_a;
        d_out        <= sat_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count <= '0;
    end else if (accept) begin
      sat_count <= '0;
    end else if (rnd_v && (clip_lo || clip_hi) && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_normalize.sv
// tb_conv_normalize: directed runs of a 16-pixel normalise pass.
// Expected writes are queued at start and popped as the DUT writes.
module tb_conv_normalize;

  localparam int N = 16;

  typedef struct {
    logic [16:0] a;
    logic [11:0] d;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic [3:0]         shift;
  logic signed [19:0] d_in;
  logic [16:0]        ReadAddress;
  logic               ReadEnable;
  logic [16:0]        WriteAddress;
  logic [11:0]        d_out;
  logic               WriteEnable;
  logic               ready;
  logic [16:0]        sat_count;

  logic signed [19:0] mem [N];
  exp_t               sb[$];
  int                 errors;
  int                 checks;

  conv_normalize #(
    .AddressBitWidth(17),
    .InBitWidth(20),
    .OutBitWidth(12),
    .NoOfPixels(N),
    .ShiftBitWidth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .shift(shift),
    .d_in(d_in),
    .ReadAddress(ReadAddress),
    .ReadEnable(ReadEnable),
    .WriteAddress(WriteAddress),
    .d_out(d_out),
    .WriteEnable(WriteEnable),
    .ready(ready),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ReadEnable) d_in <= mem[ReadAddress[3:0]];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (WriteEnable) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(WriteEnable), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(WriteAddress), 32'(e.a));
        check("wr_data", 32'(d_out), 32'(e.d));
      end
    end
  end

  function automatic logic [11:0] model(input logic signed [19:0] x,
                                        input int s,
                                        output bit clip);
    int v, d, q;
    v = x;
    if (s == 0) begin
      q = v;
    end else begin
      d = 1 << s;
      v = v + d / 2;
      q = v / d;
      if (v < 0 && (v % d) != 0) q = q - 1;
    end
    clip = (q < 0) || (q > 4095);
    if (q < 0) model = 12'd0;
    else if (q > 4095) model = 12'hfff;
    else model = q[11:0];
  endfunction

  task automatic load4(input int v0, input int v1,
                       input int v2, input int v3,
                       input int o0, input int o1,
                       input int o2, input int o3);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: begin mem[i] = 20'(v0); e.d = 12'(o0); end
        1: begin mem[i] = 20'(v1); e.d = 12'(o1); end
        2: begin mem[i] = 20'(v2); e.d = 12'(o2); end
        default: begin mem[i] = 20'(v3); e.d = 12'(o3); end
      endcase
      e.a = 17'(i);
      sb.push_back(e);
    end
  endtask

  task automatic load_rand(input int s, output int nsat);
    exp_t e;
    bit   c;
    nsat = 0;
    for (int i = 0; i < N; i++) begin
      mem[i] = 20'($urandom);
      e.a = 17'(i);
      e.d = model(mem[i], s, c);
      if (c) nsat++;
      sb.push_back(e);
    end
  endtask

  task automatic do_run(input logic [3:0] s, input int exp_sat,
                        input bit disturb);
    int lat;
    @(negedge clk);
    shift = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_re", 32'(ReadEnable), 32'd1);
    check("start_ra", 32'(ReadAddress), 32'd0);
    check("start_rdy", 32'(ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (disturb && i == 5) begin
        start = 1'b1;
        shift = ~s;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ready) lat = i;
    end
    check("ready_latency", 32'(lat), 32'(N + 3));
    check("sat_count", 32'(sat_count), 32'(exp_sat));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("re_off", 32'(ReadEnable), 32'd0);
  endtask

  initial begin
    int ns;
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    start  = 1'b0;
    shift  = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_re", 32'(ReadEnable), 32'd0);
    check("rst_ra", 32'(ReadAddress), 32'd0);
    check("rst_we", 32'(WriteEnable), 32'd0);
    check("rst_rdy", 32'(ready), 32'd0);
    check("rst_sat", 32'(sat_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // rounding: (100 + 8) >> 4 = 6
    load4(100, 100, 100, 100, 6, 6, 6, 6);
    do_run(4'd4, 0, 1'b0);

    // saturation: 65527 -> 4095 exact, 65528 -> 4096 clipped
    load4(-50, 70000, 65527, 65528, 0, 4095, 4095, 4095);
    do_run(4'd4, 12, 1'b0);

    load4(4095, 4096, -1, 0, 4095, 4095, 0, 0);
    do_run(4'd0, 8, 1'b0);

    // mid-run start/shift changes must be ignored, then restart from DONE
    load_rand(3, ns);
    do_run(4'd3, ns, 1'b1);
    check("done_rdy", 32'(ready), 32'd1);
    load_rand(7, ns);
    do_run(4'd7, ns, 1'b0);

    // reset right after the 7th write of a run
    load_rand(5, ns);
    @(negedge clk);
    shift = 4'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_left", 32'(sb.size()), 32'(N - 7));
    rst = 1'b0;
    #1;
    check("mid_rst_re", 32'(ReadEnable), 32'd0);
    check("mid_rst_ra", 32'(ReadAddress), 32'd0);
    check("mid_rst_we", 32'(WriteEnable), 32'd0);
    check("mid_rst_wa", 32'(WriteAddress), 32'd0);
    check("mid_rst_dout", 32'(d_out), 32'd0);
    check("mid_rst_rdy", 32'(ready), 32'd0);
    check("mid_rst_sat", 32'(sat_count), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_re", 32'(ReadEnable), 32'd0);
    check("post_rst_rdy", 32'(ready), 32'd0);
    load_rand(2, ns);
    do_run(4'd2, ns, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
